// File: rtl/posit_product_buffer.sv
// Show-ahead FIFO that buffers normalized posit multiplier products for a downstream consumer.
// It also tracks occupancy, a sticky drop flag and saturating counts of accepted zero and NaR products.
module posit_product_buffer #(
    parameter int NBITS = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic [NBITS-1:0]         in_result,
    input  logic                     in_inf,
    input  logic                     in_zero,
    input  logic                     in_done,
    output logic [NBITS-1:0]         out_data,
    output logic                     out_inf,
    output logic                     out_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [15:0]              zero_cnt,
    output logic [15:0]              nar_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - 1);

    logic [NBITS-1:0] mem_data [DEPTH];
    logic             mem_inf  [DEPTH];
    logic             mem_zero [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic [15:0]      zero_cnt_q;
    logic [15:0]      nar_cnt_q;

    logic             push;
    logic             pop;
    logic             drop;
    logic [NBITS-1:0] w_data;
    logic             w_inf;
    logic             w_zero;

    // Handshake: the head entry transfers on a rising edge where out_valid and out_ready are both high;
    // out_valid never depends on out_ready, and a full FIFO still accepts a product when the head leaves.
    assign pop  = out_valid & out_ready;
    assign push = in_done & ((count_q != FULL_LVL) | pop);
    assign drop = in_done & ~push;

    // NaR wins over zero; both collapse to their canonical encodings.
    always_comb begin
        w_data = in_result;
        w_inf  = 1'b0;
        w_zero = 1'b0;
        if (in_inf) begin
            w_data = {1'b1, {(NBITS-1){1'b0}}};
            w_inf  = 1'b1;
        end else if (in_zero) begin
            w_data = '0;
            w_zero = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            zero_cnt_q <= '0;
            nar_cnt_q  <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            zero_cnt_q <= '0;
            nar_cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (push && w_zero && zero_cnt_q != 16'hFFFF) begin
                zero_cnt_q <= zero_cnt_q + 16'd1;
            end
            if (push && w_inf && nar_cnt_q != 16'hFFFF) begin
                nar_cnt_q <= nar_cnt_q + 16'd1;
            end
        end
    end

    // Storage is deliberately left unreset; an empty FIFO masks it at the outputs.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_data[wr_ptr] <= w_data;
            mem_inf[wr_ptr]  <= w_inf;
            mem_zero[wr_ptr] <= w_zero;
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? mem_data[rd_ptr] : '0;
    assign out_inf     = out_valid & mem_inf[rd_ptr];
    assign out_zero    = out_valid & mem_zero[rd_ptr];
    assign count       = count_q;
    assign almost_full = (count_q >= AF_LVL);
    assign overflow    = overflow_q;
    assign zero_cnt    = zero_cnt_q;
    assign nar_cnt     = nar_cnt_q;

endmodule
